// File: rtl/ct_byte_serializer.sv
// ML-KEM-768 ciphertext serializer: packs compressed u[0..KDIM-1] (DU bits) and v (DV bits)
// from the polynomial bank into a little-endian byte stream. Optional abort input: CT_ABORT_EN.
module ct_byte_serializer #(
  parameter int U_SLOT_BASE = 16,
  parameter int V_SLOT      = 19,
  parameter int KDIM        = 3,
  parameter int DU          = 10,
  parameter int DV          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  bank_slot,
  output logic [7:0]  bank_addr,
  input  logic [11:0] bank_dout,
  output logic        dout_valid,
  output logic [7:0]  dout_data,
  input  logic        dout_ready
`ifdef CT_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam int PW = $clog2(KDIM + 1);
  localparam logic [PW-1:0] V_IDX = PW'(KDIM);
  localparam int TOTAL_BYTES = (KDIM * 256 * DU + 256 * DV) / 8;
  localparam logic [10:0] LAST_BYTE = 11'(TOTAL_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [23:0]   acc_reg, acc_next;
  logic [4:0]    nb_reg, nb_next;
  logic [7:0]    coef_reg, coef_next;
  logic [PW-1:0] poly_reg, poly_next;
  logic [10:0]   byte_cnt_reg, byte_cnt_next;

  logic          is_v;
  logic [4:0]    d_cur;
  logic [23:0]   coef_ext;
  logic [23:0]   acc_cap;
  logic [23:0]   acc_shift;
  logic [4:0]    nb_cap;
  logic [4:0]    nb_shift;
  logic          last_coef;
  logic          advance;

  assign is_v      = (poly_reg == V_IDX);
  assign d_cur     = is_v ? 5'(DV) : 5'(DU);
  // Upper bank bits beyond the coefficient width are masked off before packing.
  assign coef_ext  = {12'd0, bank_dout} & ((24'd1 << d_cur) - 24'd1);
  assign acc_cap   = acc_reg | (coef_ext << nb_reg);
  assign nb_cap    = nb_reg + d_cur;
  assign acc_shift = {8'd0, acc_reg[23:8]};
  assign nb_shift  = nb_reg - 5'd8;
  assign last_coef = is_v && (coef_reg == 8'd255);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      acc_reg      <= 24'd0;
      nb_reg       <= 5'd0;
      coef_reg     <= 8'd0;
      poly_reg     <= '0;
      byte_cnt_reg <= 11'd0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      nb_reg       <= nb_next;
      coef_reg     <= coef_next;
      poly_reg     <= poly_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    nb_next       = nb_reg;
    coef_next     = coef_reg;
    poly_next     = poly_reg;
    byte_cnt_next = byte_cnt_reg;
    advance       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          acc_next      = 24'd0;
          nb_next       = 5'd0;
          coef_next     = 8'd0;
          poly_next     = '0;
          byte_cnt_next = 11'd0;
          state_next    = S_FETCH;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        acc_next = acc_cap;
        nb_next  = nb_cap;
        if (nb_cap >= 5'd8) begin
          state_next = S_EMIT;
        end else begin
          advance    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EMIT: begin
        if (dout_ready) begin
          acc_next      = acc_shift;
          nb_next       = nb_shift;
          byte_cnt_next = byte_cnt_reg + 11'd1;
          if (nb_shift >= 5'd8) begin
            state_next = S_EMIT;
          end else if (last_coef && (nb_shift == 5'd0) && (byte_cnt_reg == LAST_BYTE)) begin
            state_next = S_DONE;
          end else begin
            advance    = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (advance) begin
      if (coef_reg == 8'd255) begin
        coef_next = 8'd0;
        poly_next = poly_reg + PW'(1);
      end else begin
        coef_next = coef_reg + 8'd1;
      end
    end

`ifdef CT_ABORT_EN
    // Abort wins over any handshake in the same cycle.
    if (abort && (state_reg != S_IDLE)) begin
      state_next    = S_IDLE;
      acc_next      = 24'd0;
      nb_next       = 5'd0;
      coef_next     = 8'd0;
      poly_next     = '0;
      byte_cnt_next = 11'd0;
    end
`endif
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign dout_valid = (state_reg == S_EMIT);
  assign dout_data  = dout_valid ? acc_reg[7:0] : 8'd0;
  assign bank_slot  = (state_reg == S_FETCH) ?
                      (is_v ? 5'(V_SLOT) : 5'(U_SLOT_BASE) + 5'(poly_reg)) : 5'd0;
  assign bank_addr  = (state_reg == S_FETCH) ? coef_reg : 8'd0;

endmodule

// File: tb/tb_ct_byte_serializer.sv
// Directed bench for ct_byte_serializer: bank model with 1-cycle registered read,
// bit-serial ByteEncode reference, byte/done monitor sampled on the falling edge.
module tb_ct_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  bank_slot;
  logic [7:0]  bank_addr;
  logic [11:0] bank_dout;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic        dout_ready;
`ifdef CT_ABORT_EN
  logic        abort;
`endif

  int total = 0;
  int bad   = 0;

  logic [11:0] mem [0:31][0:255];
  logic [7:0]  exp_bytes [0:1087];
  logic [7:0]  got [$];
  int          done_cnt   = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'd0;

  ct_byte_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bank_slot  (bank_slot),
    .bank_addr  (bank_addr),
    .bank_dout  (bank_dout),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready)
`ifdef CT_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) bank_dout <= mem[bank_slot][bank_addr];

  // Falling-edge monitor: a byte sampled with valid && ready is taken at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (dout_valid && dout_ready) got.push_back(dout_data);
      if (prev_stall && (!dout_valid || dout_data !== prev_data)) stall_viol <= stall_viol + 1;
      prev_stall <= dout_valid && !dout_ready;
      prev_data  <= dout_data;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic clear_mem();
    for (int s = 0; s < 32; s++)
      for (int i = 0; i < 256; i++) mem[s][i] = 12'd0;
  endtask

  task automatic random_mem();
    clear_mem();
    for (int s = 16; s < 20; s++)
      for (int i = 0; i < 256; i++) mem[s][i] = 12'($urandom);
  endtask

  // Reference ByteEncode: one bit at a time, LSB-first, u[0..2] then v.
  task automatic build_model();
    int k;
    int slot;
    int d;
    k = 0;
    for (int i = 0; i < 1088; i++) exp_bytes[i] = 8'd0;
    for (int p = 0; p < 4; p++) begin
      slot = (p < 3) ? 16 + p : 19;
      d    = (p < 3) ? 10 : 4;
      for (int i = 0; i < 256; i++)
        for (int b = 0; b < d; b++) begin
          if (mem[slot][i][b]) exp_bytes[k / 8][k % 8] = 1'b1;
          k++;
        end
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got.size() < 1088) ? got.size() : 1088;
    for (int i = 0; i < n; i++)
      if (got[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    pulse_start();
    for (int c = 0; c < 12000; c++) begin
      @(posedge clk); #1;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dout_ready = 1'b1;
`ifdef CT_ABORT_EN
    abort = 1'b0;
`endif
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dout_valid); end
    total++; if (dout_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", dout_data); end
    total++; if (bank_slot !== 5'd0) begin bad++; $display("FAIL reset_slot got=%0d want=0", bank_slot); end
    total++; if (bank_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bank_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    $display("test_reset: checked reset outputs");
  endtask

  task automatic test_small_coeffs();
    logic [7:0] want [5];
    bit ok;
    int d0;
    int fd;
    want = '{8'h01, 8'h08, 8'h30, 8'h00, 8'h01};
    clear_mem();
    mem[16][0] = 12'd1; mem[16][1] = 12'd2; mem[16][2] = 12'd3; mem[16][3] = 12'd4;
    build_model();
    got.delete();
    d0 = done_cnt;
    run_to_done(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL small_done_timeout got=none want=done"); end
    total++; if (got.size() != 1088) begin bad++; $display("FAIL small_count got=%0d want=1088", got.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL small_byte%0d got=%h want=%h", i, got[i], want[i]); end
    end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL small_stream idx=%0d got=%h want=%h", fd, got[fd], exp_bytes[fd]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL small_done_pulses got=%0d want=1", done_cnt - d0); end
    $display("test_small_coeffs: %0d bytes, first %h %h %h %h %h", got.size(), got[0], got[1], got[2], got[3], got[4]);
  endtask

  task automatic test_upper_bits();
    logic [7:0] want [5];
    bit ok;
    int fd;
    want = '{8'hFF, 8'h03, 8'h00, 8'h00, 8'h00};
    clear_mem();
    mem[16][0] = 12'hFFF; mem[16][1] = 12'hC00; mem[16][2] = 12'hC00; mem[16][3] = 12'hC00;
    build_model();
    got.delete();
    run_to_done(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL upper_done_timeout got=none want=done"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL upper_byte%0d got=%h want=%h", i, got[i], want[i]); end
    end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL upper_stream idx=%0d got=%h want=%h", fd, got[fd], exp_bytes[fd]); end
    $display("test_upper_bits: %0d bytes, first %h %h", got.size(), got[0], got[1]);
  endtask

  task automatic test_v_nibbles();
    bit ok;
    int nz;
    clear_mem();
    mem[19][0] = 12'hA; mem[19][1] = 12'h5;
    got.delete();
    run_to_done(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL v_done_timeout got=none want=done"); end
    total++; if (got.size() != 1088) begin bad++; $display("FAIL v_count got=%0d want=1088", got.size()); end
    total++; if (got[960] !== 8'h5A) begin bad++; $display("FAIL v_byte960 got=%h want=5a", got[960]); end
    nz = 0;
    for (int i = 0; i < 960 && i < got.size(); i++) if (got[i] !== 8'h00) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL v_u_zero got=%0d nonzero want=0", nz); end
    $display("test_v_nibbles: byte960=%h", got[960]);
  endtask

  task automatic test_random_stall();
    bit ok;
    int fd;
    int sv0;
    int d0;
    random_mem();
    build_model();
    got.delete();
    sv0 = stall_viol;
    d0 = done_cnt;
    run_to_done(1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_done_timeout got=none want=done"); end
    total++; if (got.size() != 1088) begin bad++; $display("FAIL rand_count got=%0d want=1088", got.size()); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL rand_stream idx=%0d got=%h want=%h", fd, got[fd], exp_bytes[fd]); end
    total++; if (stall_viol != sv0) begin bad++; $display("FAIL rand_stall_stable got=%0d want=0", stall_viol - sv0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rand_done_pulses got=%0d want=1", done_cnt - d0); end
    $display("test_random_stall: %0d bytes with random ready", got.size());
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    int fd;
    int d0;
    random_mem();
    build_model();
    got.delete();
    d0 = done_cnt;
    hit = 1'b0;
    pulse_start();
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 500) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rstmid_reach500 got=%0d want=500", got.size()); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_async got=%b want=0", busy); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", dout_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_cnt, d0); end
    got.delete();
    run_to_done(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_done_timeout got=none want=done"); end
    total++; if (got.size() != 1088) begin bad++; $display("FAIL rstmid_count got=%0d want=1088", got.size()); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL rstmid_stream idx=%0d got=%h want=%h", fd, got[fd], exp_bytes[fd]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rstmid_done_pulses got=%0d want=1", done_cnt - d0); end
    $display("test_reset_mid: restarted stream of %0d bytes", got.size());
  endtask

`ifdef CT_ABORT_EN
  task automatic test_abort();
    bit hit;
    bit ok;
    int fd;
    int d0;
    random_mem();
    build_model();
    got.delete();
    d0 = done_cnt;
    hit = 1'b0;
    pulse_start();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 100) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach100 got=%0d want=100", got.size()); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", dout_valid); end
    repeat (10) @(posedge clk);
    #1;
    total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done got=%0d want=%0d", done_cnt, d0); end
    got.delete();
    run_to_done(1'b0, ok);
    fd = first_diff();
    total++; if (!ok || got.size() != 1088 || fd != -1) begin
      bad++; $display("FAIL abort_restart got=%0d bytes idx=%0d want=1088 bytes idx=-1", got.size(), fd);
    end
    $display("test_abort: aborted at byte 100, restart gave %0d bytes", got.size());
  endtask
`else
  task automatic test_start_while_busy();
    bit hit;
    bit ok;
    int fd;
    int d0;
    random_mem();
    build_model();
    got.delete();
    d0 = done_cnt;
    hit = 1'b0;
    ok = 1'b0;
    pulse_start();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 100) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL busystart_reach100 got=%0d want=100", got.size()); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (20) @(posedge clk);
    #1;
    total++; if (!ok) begin bad++; $display("FAIL busystart_done_timeout got=none want=done"); end
    total++; if (got.size() != 1088) begin bad++; $display("FAIL busystart_count got=%0d want=1088", got.size()); end
    fd = first_diff();
    total++; if (fd != -1) begin bad++; $display("FAIL busystart_stream idx=%0d got=%h want=%h", fd, got[fd], exp_bytes[fd]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busystart_done_pulses got=%0d want=1", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busystart_idle got=%b want=0", busy); end
    $display("test_start_while_busy: %0d bytes, done pulses %0d", got.size(), done_cnt - d0);
  endtask
`endif

  initial begin
    test_reset();
    test_small_coeffs();
    test_upper_bits();
    test_v_nibbles();
    test_random_stall();
    test_reset_mid();
`ifdef CT_ABORT_EN
    test_abort();
`else
    test_start_while_busy();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
